// File: rtl/uart_rx_ctrl.sv
// UART receive controller: 16x oversampled start/data/stop sequencing,
// LSB-first deserialisation, false-start filtering and framing-error flag.
module uart_rx_ctrl #(
  parameter int unsigned D_BIT   = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             rx,
  output logic [D_BIT-1:0] dout,
  output logic             rx_done_tick,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned SMAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int unsigned SW   = $clog2(SMAX);
  localparam int unsigned NW   = $clog2(D_BIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

  logic [1:0]       state;
  logic [SW-1:0]    s;
  logic [NW-1:0]    n;
  logic [D_BIT-1:0] b;
  logic             rx_meta;
  logic             rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_meta      <= rx;
      rx_s         <= rx_meta;
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Edge detection runs every clock, independent of s_tick.
          if (!rx_s) begin
            state <= START;
            s     <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                n     <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              s <= s + S_ONE;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[D_BIT-1:1]};
              if (n == N_LAST) state <= STOP;
              else             n     <= n + N_ONE;
            end else begin
              s <= s + S_ONE;
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              state        <= IDLE;
              busy         <= 1'b0;
              dout         <= b;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
            end else begin
              s <= s + S_ONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: good frames, glitch, framing error,
// back-to-back frames, mid-frame reset and s_tick stall.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic tick_en = 1'b1;
  int   tick_div = 0;
  int   tick_cnt = 0;
  int   fstart = 0;

  int         done_cnt = 0;
  int         dbl_cnt = 0;
  logic       prev_done = 1'b0;
  int         pulse_tick [64];
  logic [7:0] pulse_dout [64];
  logic       pulse_ferr [64];

  uart_rx_ctrl #(.D_BIT(8), .SB_TICK(16)) dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // One s_tick every 4 clocks, changed away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      s_tick = tick_en && (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      if (prev_done) dbl_cnt++;
      pulse_tick[done_cnt % 64] = tick_cnt;
      pulse_dout[done_cnt % 64] = dout;
      pulse_ferr[done_cnt % 64] = frame_err;
      done_cnt++;
    end
    prev_done = rx_done_tick;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (!s_tick && k < 40);
    if (!s_tick) check_eq("tick_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic freeze_ticks();
    int n0;
    logic [7:0] d0;
    n0 = done_cnt;
    d0 = dout;
    tick_en = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_eq("freeze_busy", busy, 1);
    check_eq("freeze_nodone", done_cnt, n0);
    check_eq("freeze_dout", dout, d0);
    tick_en = 1'b1;
  endtask

  // Caller must be aligned just after a tick edge; frame starts immediately.
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int stop_ticks, input int freeze_bit);
    rx = 1'b0;
    fstart = tick_cnt;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == freeze_bit) begin
        wait_ticks(5);
        freeze_ticks();
        wait_ticks(11);
      end else begin
        wait_ticks(16);
      end
    end
    rx = stop_v;
    wait_ticks(stop_ticks);
    rx = 1'b1;
  endtask

  initial begin
    int n0;
    logic [7:0] d5a;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_done", rx_done_tick, 0);
    check_eq("rst_ferr", frame_err, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    wait_ticks(4);
    check_eq("idle_busy", busy, 0);

    // Good frame 0xA5
    n0 = done_cnt;
    send_frame(8'hA5, 1'b1, 16, -1);
    check_eq("a5_count", done_cnt, n0 + 1);
    check_eq("a5_dout", dout, 8'hA5);
    check_eq("a5_ferr", frame_err, 0);
    check_eq("a5_busy", busy, 0);
    check_eq("a5_len", pulse_tick[n0 % 64] - fstart, 152);
    wait_ticks(4);

    // Glitch shorter than half a bit
    n0 = done_cnt;
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(2);
    check_eq("glitch_busy_hi", busy, 1);
    wait_ticks(10);
    check_eq("glitch_busy_lo", busy, 0);
    check_eq("glitch_nodone", done_cnt, n0);
    check_eq("glitch_dout", dout, 8'hA5);
    check_eq("glitch_ferr", frame_err, 0);

    // Framing error; stop line returns high just after the stop sample
    n0 = done_cnt;
    send_frame(8'h3C, 1'b0, 8, -1);
    wait_ticks(24);
    check_eq("ferr_count", done_cnt, n0 + 1);
    check_eq("ferr_dout", pulse_dout[n0 % 64], 8'h3C);
    check_eq("ferr_flag", pulse_ferr[n0 % 64], 1);
    check_eq("ferr_held", frame_err, 1);
    check_eq("ferr_busy", busy, 0);

    n0 = done_cnt;
    send_frame(8'h81, 1'b1, 16, -1);
    check_eq("f81_count", done_cnt, n0 + 1);
    check_eq("f81_dout", dout, 8'h81);
    check_eq("f81_ferr", frame_err, 0);
    wait_ticks(4);

    // Back-to-back: next start right after the first stop sample
    n0 = done_cnt;
    send_frame(8'h00, 1'b1, 8, -1);
    send_frame(8'hFF, 1'b1, 16, -1);
    check_eq("b2b_count", done_cnt, n0 + 2);
    check_eq("b2b_dout0", pulse_dout[n0 % 64], 8'h00);
    check_eq("b2b_dout1", pulse_dout[(n0 + 1) % 64], 8'hFF);
    check_eq("b2b_gap", pulse_tick[(n0 + 1) % 64] - pulse_tick[n0 % 64], 152);
    check_eq("b2b_ferr", frame_err, 0);
    wait_ticks(4);

    // Reset after start + 3 data bits of 0x5A
    n0 = done_cnt;
    d5a = 8'h5A;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = d5a[i];
      wait_ticks(16);
    end
    check_eq("pre_rst_busy", busy, 1);
    rst = 1'b0;
    rx = 1'b1;
    #2;
    check_eq("mrst_dout", dout, 8'h00);
    check_eq("mrst_ferr", frame_err, 0);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_done", rx_done_tick, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    wait_ticks(20);
    check_eq("mrst_nodone", done_cnt, n0);
    send_frame(8'h5A, 1'b1, 16, -1);
    check_eq("f5a_count", done_cnt, n0 + 1);
    check_eq("f5a_dout", dout, 8'h5A);
    check_eq("f5a_ferr", frame_err, 0);
    wait_ticks(4);

    // s_tick stalled for 100 clk in the middle of bit 4
    n0 = done_cnt;
    send_frame(8'hC3, 1'b1, 16, 4);
    check_eq("frz_count", done_cnt, n0 + 1);
    check_eq("frz_dout", dout, 8'hC3);
    check_eq("frz_len", pulse_tick[n0 % 64] - fstart, 152);
    check_eq("frz_busy", busy, 0);

    check_eq("done_single_cycle", dbl_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART module. It drives the oversampling tick counter, the data-bit counter and the shift register that deserialise the `rx` line into a D_BIT-wide word. It sits between the baud-rate tick generator, which supplies `s_tick` at 16× the baud rate, and the receive FIFO or user logic, which consumes `dout` on `rx_done_tick`. It also flags false starts and framing errors.

## Interface
- D_BIT, 8, number of data bits per frame (LSB first); legal range 5–9
- SB_TICK, 16, number of `s_tick` periods spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk
- s_tick  in  1  one-clk-wide oversampling strobe at 16× baud rate
- rx  in  1  serial input, asynchronous to clk, idle high
- dout  out  D_BIT  last received word; held until the next frame completes
- rx_done_tick  out  1  one-clk pulse when a frame completes (good or bad)
- frame_err  out  1  stop-bit value of the last completed frame was 0; valid with `rx_done_tick`, held until the next completion
- busy  out  1  high in every state except IDLE

## Operation
- `rx` passes through a 2-flop synchroniser reset to 1. The FSM sees only the synchronised `rx_s`.
- Internal registers:
  - state (IDLE, START, DATA, STOP)
  - s, the tick counter, width clog2(max(16,SB_TICK))
  - n, the bit counter, width clog2(D_BIT)
  - b, the D_BIT shift register
- Counters advance only on cycles with `s_tick`=1. Without `s_tick`, all state and counters hold.
- IDLE: if `rx_s`=0, go to START and set s=0. This check does not require `s_tick`.
- START, on `s_tick`:
  - if s==7 and `rx_s`=0: go to DATA, set s=0 and n=0.
  - if s==7 and `rx_s`=1: false start; go to IDLE with no outputs changed.
  - otherwise: s=s+1.
- DATA, on `s_tick`:
  - if s==15: set s=0 and b={rx_s, b[D_BIT-1:1]}; if n==D_BIT-1, go to STOP, else n=n+1.
  - otherwise: s=s+1.
- STOP, on `s_tick`:
  - if s==SB_TICK-1: go to IDLE, load dout=b, set frame_err=~rx_s, pulse rx_done_tick.
  - otherwise: s=s+1.
- A framing error does not block reception. If `rx_s` is still 0 on return to IDLE, START is re-entered and the mid-sample check filters a line break.
- Counter arithmetic is unsigned. s and n never wrap, because each reaches its terminal value and is cleared before overflow.

## Timing
- Reset values:
  - state=IDLE, s=0, n=0, b=0
  - dout=0, rx_done_tick=0, frame_err=0, busy=0
  - synchroniser flops=1
- Synchroniser latency: a falling edge on `rx` is seen by the FSM 2 clk later. IDLE→START happens on the next edge after that.
- All outputs are registered.
  - `rx_done_tick`, `dout` and `frame_err` update on the clock edge that consumes the terminal stop `s_tick`.
  - `rx_done_tick` is high for exactly one clk and is never high for two consecutive cycles.
- Sampling: the start bit is checked at its midpoint, 8 ticks after the detected edge. Each data and stop bit is then sampled 16 ticks later, also at its midpoint.
- Frame length after start detection: 8 + 16·D_BIT + SB_TICK ticks. Default: 8+128+16 = 152 ticks.
- `busy` rises on the edge entering START and falls on the edge entering IDLE.
- Asynchronous reset in any state forces the reset values within the same cycle and discards the partial frame. No `rx_done_tick` is generated for it.
- Back-to-back frames: a new start bit is accepted in the cycle immediately after the STOP→IDLE transition. No idle gap is required beyond the stop bit.

## Test plan
- Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), `s_tick` every 4 clk, 16 ticks per bit → exactly one `rx_done_tick`, dout=0xA5, frame_err=0, busy low afterwards.
- Glitch: `rx` low for 5 ticks, then high → return to IDLE after the s==7 check; no `rx_done_tick`; dout and frame_err unchanged.
- Framing error: frame 0x3C with stop bit 0 → `rx_done_tick` pulses, dout=0x3C, frame_err=1. The next good frame 0x81 → dout=0x81, frame_err=0.
- Back-to-back: 0x00 then 0xFF with zero idle between stop and next start → two pulses exactly 152 ticks apart, dout 0x00 then 0xFF.
- Reset mid-DATA (after 3 bits of 0x5A) → all outputs 0 immediately, busy=0, no pulse; the following frame 0x5A is received correctly.
- `s_tick` held low for 100 clk mid-DATA → state, s and n frozen. Resuming ticks completes the frame with the correct dout.
